// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: maps byte-addressed RV32I loads/stores onto a word-addressed RAM,
// doing read-modify-write for sub-word stores and sign/zero extension for loads.
module lsu_mem_ctrl #(
    parameter int unsigned WORD_AW = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_store,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_fault,
    output logic [WORD_AW-1:0] ram_address,
    output logic [31:0]        ram_data_in,
    output logic               ram_store,
    output logic               ram_load,
    input  logic [31:0]        ram_data_out
);

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

    state_e               state_q, state_d;
    logic                 store_q;
    logic [2:0]           funct3_q;
    logic [WORD_AW+1:0]   addr_q;
    logic [31:0]          wdata_q;
    logic                 fault_q;
    logic [31:0]          merge_q;
    logic [31:0]          rdata_q;

    logic                 accept;
    logic                 req_fault;
    logic [31:0]          load_data;
    logic [31:0]          merged;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;

    assign accept = req_valid && (state_q == StIdle);

    // Fault decode runs on the inputs at the accept edge, so it equals the latched view.
    always_comb begin
        req_fault = 1'b0;
        if (req_addr[31:WORD_AW+2] != '0) req_fault = 1'b1;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) begin
            req_fault = 1'b1;
        end
        if (req_store && req_funct3[2]) req_fault = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_fault = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_fault = 1'b1;
    end

    always_comb begin
        ld_byte = ram_data_out[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? ram_data_out[31:16] : ram_data_out[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'h0, ld_byte};
            3'b101:  load_data = {16'h0, ld_half};
            default: load_data = ram_data_out;
        endcase
    end

    always_comb begin
        merged = merge_q;
        case (funct3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            fault_q  <= 1'b0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[WORD_AW+1:0];
                wdata_q  <= req_wdata;
                fault_q  <= req_fault;
            end
            if (state_q == StLoad) rdata_q <= load_data;
            if (state_q == StRmwRd) merge_q <= ram_data_out;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        ram_load    = 1'b0;
        ram_store   = 1'b0;
        ram_data_in = 32'h0;
        resp_valid  = 1'b0;
        resp_fault  = 1'b0;
        resp_rdata  = 32'h0;
        ram_address = addr_q[WORD_AW+1:2];
        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault)                      state_d = StResp;
                    else if (!req_store)                state_d = StLoad;
                    else if (req_funct3[1:0] == 2'b10)  state_d = StWrite;
                    else                                state_d = StRmwRd;
                end
            end
            StLoad: begin
                ram_load = 1'b1;
                state_d  = StResp;
            end
            StRmwRd: begin
                ram_load = 1'b1;
                state_d  = StWrite;
            end
            StWrite: begin
                ram_store   = 1'b1;
                ram_data_in = merged;
                state_d     = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                if (!store_q && !fault_q) resp_rdata = rdata_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a behavioural 4096x32 RAM.
module tb_lsu_mem_ctrl;

    localparam int unsigned WORD_AW = 12;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_store = 1'b0;
    logic [2:0]         req_funct3 = 3'b000;
    logic [31:0]        req_addr = 32'h0;
    logic [31:0]        req_wdata = 32'h0;
    logic               resp_valid;
    logic [31:0]        resp_rdata;
    logic               resp_fault;
    logic [WORD_AW-1:0] ram_address;
    logic [31:0]        ram_data_in;
    logic               ram_store;
    logic               ram_load;
    logic [31:0]        ram_data_out;

    logic [31:0] mem [4096] = '{default: 32'h0};

    typedef struct {
        logic               fault;
        logic [31:0]        rdata;
        int                 lat;
        int                 acc;
        int                 writes;
        int                 sc;
        logic [WORD_AW-1:0] waddr;
        logic [31:0]        wdata;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   store_cycles = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (ram_store) mem[ram_address] <= ram_data_in;
    assign ram_data_out = mem[ram_address];

    lsu_mem_ctrl #(.WORD_AW(WORD_AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_store    (ram_store),
        .ram_load     (ram_load),
        .ram_data_out (ram_data_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per response; also checks write beats against the head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("ld_st_exclusive", {31'h0, ram_load & ram_store}, 32'h0);
                if (ram_store) begin
                    store_cycles++;
                    if (exp_q.size() > 0) begin
                        check("wr_addr", {20'h0, ram_address}, {20'h0, exp_q[0].waddr});
                        check("wr_data", ram_data_in, exp_q[0].wdata);
                        check("wr_cycle", cyc - exp_q[0].acc, exp_q[0].lat - 1);
                    end
                end
                if (resp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got resp_valid=1, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_fault", {31'h0, resp_fault}, {31'h0, e.fault});
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_latency", cyc - e.acc, e.lat);
                        check("write_beats", store_cycles - e.sc, e.writes);
                    end
                end
            end
        end
    end

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic ef, input logic [31:0] er,
                            input int lat, input int wr, input logic [31:0] ewd);
        exp_t e;
        e.fault  = ef;
        e.rdata  = er;
        e.lat    = lat;
        e.acc    = cyc;
        e.writes = wr;
        e.sc     = store_cycles;
        e.waddr  = a[WORD_AW+1:2];
        e.wdata  = ewd;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0, expected 1");
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic ef, input logic [31:0] er,
                         input int lat, input int wr, input logic [31:0] ewd, input bit push);
        @(negedge clk);
        drive(st, f3, a, wd);
        req_valid = 1'b1;
        wait_ready();
        if (push) push_exp(a, ef, er, lat, wr, ewd);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic ef, input logic [31:0] er,
                       input int lat, input int wr, input logic [31:0] ewd);
        issue(st, f3, a, wd, ef, er, lat, wr, ewd, 1'b1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_fault", {31'h0, resp_fault}, 32'h0);
        check("rst_ram_store", {31'h0, ram_store}, 32'h0);
        check("rst_ram_load", {31'h0, ram_load}, 32'h0);
        check("rst_ram_address", {20'h0, ram_address}, 32'h0);
        check("rst_ram_data_in", ram_data_in, 32'h0);
        rst = 1'b0;
        #1 check("rst_req_ready", {31'h0, req_ready}, 32'h1);

        // Word store and load-back
        run(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1, 32'hDEAD_BEEF);
        run(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 32'h0);
        // Sub-word loads
        run(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFF_FFBE, 2, 0, 32'h0);
        run(1'b0, 3'b100, 32'h11, 32'h0, 1'b0, 32'h0000_00BE, 2, 0, 32'h0);
        run(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF_DEAD, 2, 0, 32'h0);
        run(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000_DEAD, 2, 0, 32'h0);
        // Sub-word stores via read-modify-write
        run(1'b1, 3'b000, 32'h13, 32'h0000_0055, 1'b0, 32'h0, 3, 1, 32'h55AD_BEEF);
        run(1'b1, 3'b001, 32'h10, 32'h0000_1234, 1'b0, 32'h0, 3, 1, 32'h55AD_1234);
        check("mem_word4", mem[4], 32'h55AD_1234);
        // Faults
        run(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0);
        run(1'b0, 3'b001, 32'h11, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0);
        run(1'b1, 3'b010, 32'h0000_4000, 32'h1111_1111, 1'b1, 32'h0, 1, 0, 32'h0);
        run(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0);
        run(1'b1, 3'b100, 32'h10, 32'h0000_00AA, 1'b1, 32'h0, 1, 0, 32'h0);
        check("mem_word4_after_faults", mem[4], 32'h55AD_1234);

        // req_valid held across two requests
        @(negedge clk);
        drive(1'b0, 3'b010, 32'h10, 32'h0);
        req_valid = 1'b1;
        wait_ready();
        push_exp(32'h10, 1'b0, 32'h55AD_1234, 2, 0, 32'h0);
        @(posedge clk);
        #1 drive(1'b1, 3'b010, 32'h14, 32'h0BAD_F00D);
        @(negedge clk);
        check("ready_in_load", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("ready_in_resp", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("ready_after_resp", {31'h0, req_ready}, 32'h1);
        push_exp(32'h14, 1'b0, 32'h0, 2, 1, 32'h0BAD_F00D);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();
        check("mem_word5", mem[5], 32'h0BAD_F00D);

        // Reset during WRITE of an SB must abort the write
        run(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0, 2, 1, 32'hCAFE_F00D);
        issue(1'b1, 3'b000, 32'h20, 32'h0000_0077, 1'b0, 32'h0, 3, 1, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("store_before_rst", {31'h0, ram_store}, 32'h1);
        rst = 1'b1;
        #1;
        check("store_drops_on_rst", {31'h0, ram_store}, 32'h0);
        check("no_resp_on_rst", {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready_after_rst", {31'h0, req_ready}, 32'h1);
        check("mem_word8_kept", mem[8], 32'hCAFE_F00D);
        run(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 0, 32'h0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit between the core's memory stage and the word-addressed data RAM (4096 x 32, synchronous write, combinational read).
- Converts byte-addressed RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM word accesses.
- Handles sub-word stores by read-modify-write, extends load data by sign or zero, and flags misaligned, out-of-range and illegal-funct3 requests.
- Uses a valid/ready request handshake and a single-cycle response pulse.

Parameters:
- WORD_AW, 12, RAM word-address width; byte address space is 2^(WORD_AW+2) bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low bits are used for B/H.
- resp_valid  output  1  one-cycle pulse when the request completes.
- resp_rdata  output  32  extended load data; 0 for stores and faults.
- resp_fault  output  1  qualified by resp_valid; request rejected.
- ram_address  output  WORD_AW  word index into RAM.
- ram_data_in  output  32  word to write.
- ram_store  output  1  RAM write enable.
- ram_load  output  1  RAM read enable.
- ram_data_out  input  32  RAM read word.

Behaviour:
- One clock; reset is asynchronous and active-high, on clk and rst.
- Reset values: state IDLE; resp_valid 0; resp_rdata 0; resp_fault 0; ram_store 0; ram_load 0; ram_address 0; ram_data_in 0. req_ready is 1 as soon as reset is released.
- Accept: a handshake completes when req_valid and req_ready are both high at a rising edge. At that edge the unit latches store, funct3, addr and wdata. Inputs are ignored outside IDLE.
- Fault checks are evaluated on the latched request. Any one of these is a fault:
  - addr[31:WORD_AW+2] is nonzero.
  - funct3 is 011, 110 or 111.
  - A store has funct3[2] = 1.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 00.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Transitions from IDLE on accept:
  - Fault -> RESP with fault set.
  - Load -> LOAD.
  - SW -> WRITE.
  - SB or SH -> RMW_RD.
- LOAD: ram_load = 1; ram_address = addr[WORD_AW+1:2]. At the edge, capture the extracted and extended data into resp_rdata. Next state RESP.
- Load extraction:
  - The byte is selected by addr[1:0] and the halfword by addr[1].
  - B and H sign-extend; BU and HU zero-extend.
  - W passes the word through.
- RMW_RD: ram_load = 1. At the edge, capture ram_data_out into a merge register. Next state WRITE.
- Store merge (WRITE): ram_store = 1 and ram_data_in = merged word.
  - SW: the merged word is wdata.
  - SB: wdata[7:0] replaces byte lane addr[1:0].
  - SH: wdata[15:0] replaces halfword lane addr[1].
  - Next state RESP. The RAM commits the write at the edge that leaves WRITE.
- RESP: resp_valid = 1 for exactly one cycle. resp_fault = fault; resp_rdata = 0 if store or fault. Next state IDLE.
- ram_load and ram_store are never high together. Both are 0 in IDLE and RESP.
- Latency from accept edge to resp_valid:
  - Fault: 1 cycle.
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
- Back-to-back: the next accept is possible in the cycle after RESP. There is no overlap and no pipelining.
- Reset mid-operation: the FSM returns to IDLE immediately and ram_store drops asynchronously. A write whose WRITE-exit edge has not occurred is not committed. No resp_valid is produced for the aborted request.
- Uninitialised RAM words read as 0 at the RAM.

Test Plan:
- Reset, then SW addr 0x0000_0010 wdata 0xDEAD_BEEF -> ram_store high in cycle 1 with ram_address 4. resp_valid in cycle 2 with fault 0. A following LW from 0x10 returns 0xDEAD_BEEF 2 cycles after accept.
- With word 4 = 0xDEAD_BEEF: LB 0x11 -> 0xFFFF_FFBE; LBU 0x11 -> 0x0000_00BE; LH 0x12 -> 0xFFFF_DEAD; LHU 0x12 -> 0x0000_DEAD.
- SB 0x13 wdata 0x0000_0055 -> RMW_RD then WRITE; ram_data_in = 0x55AD_BEEF; response 3 cycles after accept. Then SH 0x10 wdata 0x1234 -> word becomes 0x55AD_1234.
- Faults, each giving resp_fault 1 one cycle after accept with no ram_store: LW 0x12; LH 0x11; SW 0x0000_4000 (out of range); load with funct3 011; SB with funct3 100.
- Hold req_valid high continuously across LW 0x10 then SW 0x14 -> req_ready low during LOAD and RESP. The second accept happens in the cycle after RESP; no request is lost or duplicated.
- Assert rst while in WRITE of SB 0x20, before the edge -> ram_store drops immediately, word 8 is unchanged, no resp_valid, and req_ready is 1 after release.
